// File: rtl/spin_profile_gen_pkg.sv
// Shared types and defaults for the spin profile generator.
package spin_pkg;
    localparam int DUTY_W = 10;

    typedef enum logic [1:0] {IDLE, ACCEL, HOLD, DECEL} spin_state_t;
endpackage

// File: rtl/spin_profile_gen_ramp_tick_gen.sv
// Ramp time base: one tick every STEP_DIV cycles while enabled, parked at zero otherwise.
module ramp_tick_gen #(
    parameter int STEP_DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);
    localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_DIV - 1);

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;

    always_comb begin
        tick      = en && (div_cnt_q == LAST);
        div_cnt_d = '0;
        if (en && (div_cnt_q != LAST)) begin
            div_cnt_d = div_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end
endmodule

// File: rtl/spin_profile_gen.sv
// Duty-cycle trajectory for one wheel spin: ramp up to a peak, hold, ramp down to zero.
module spin_profile_gen
    import spin_pkg::*;
#(
    parameter int DUTY_W    = spin_pkg::DUTY_W,
    parameter int STEP_DIV  = 100000,
    parameter int STEP_SIZE = 4,
    parameter int HOLD_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DUTY_W-1:0] peak_duty,
    input  logic [HOLD_W-1:0] hold_ticks,
    input  logic              abort,
    output logic [DUTY_W-1:0] duty_cycle,
    output logic              busy,
    output logic              done
);
    localparam logic [DUTY_W:0]   STEP_WIDE = (DUTY_W + 1)'(STEP_SIZE);
    localparam logic [DUTY_W-1:0] STEP      = DUTY_W'(STEP_SIZE);

    spin_state_t       state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DUTY_W-1:0] peak_q, peak_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DUTY_W:0]   up_sum;
    logic              tick;

    ramp_tick_gen #(.STEP_DIV(STEP_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (busy_q),
        .tick  (tick)
    );

    always_comb begin
        state_d    = state_q;
        duty_d     = duty_q;
        peak_d     = peak_q;
        hold_d     = hold_q;
        hold_cnt_d = hold_cnt_q;
        done_d     = 1'b0;
        // Wide sum so a peak near full scale cannot wrap before saturation.
        up_sum     = {1'b0, duty_q} + STEP_WIDE;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    peak_d  = peak_duty;
                    hold_d  = hold_ticks;
                    state_d = (peak_duty == '0) ? DECEL : ACCEL;
                end
            end
            ACCEL: begin
                if (abort) begin
                    state_d = DECEL;
                end else if (duty_q == peak_q) begin
                    state_d    = HOLD;
                    hold_cnt_d = '0;
                end else if (tick) begin
                    duty_d = (up_sum > {1'b0, peak_q}) ? peak_q : up_sum[DUTY_W-1:0];
                end
            end
            HOLD: begin
                if (abort || (hold_cnt_q == hold_q)) begin
                    state_d = DECEL;
                end else if (tick) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            DECEL: begin
                if (duty_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (tick) begin
                    duty_d = (duty_q <= STEP) ? '0 : duty_q - STEP;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            duty_q     <= '0;
            peak_q     <= '0;
            hold_q     <= '0;
            hold_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            duty_q     <= duty_d;
            peak_q     <= peak_d;
            hold_q     <= hold_d;
            hold_cnt_q <= hold_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign duty_cycle = duty_q;
    assign busy       = busy_q;
    assign done       = done_q;
endmodule

// File: tb/tb_spin_profile_gen.sv
// Bench for spin_profile_gen: cycle model compared every cycle plus hand-computed checkpoints.
module tb_spin_profile_gen;
    localparam int DUTY_W = 10;
    localparam int HOLD_W = 16;
    localparam int SD     = 4;
    localparam int SS     = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [DUTY_W-1:0] peak_duty = '0;
    logic [HOLD_W-1:0] hold_ticks = '0;
    logic              abort = 1'b0;
    logic [DUTY_W-1:0] duty_cycle;
    logic              busy;
    logic              done;

    int npass = 0;
    int ntotal = 0;
    int cyc = 0;
    int acc = 0;

    spin_profile_gen #(
        .DUTY_W(DUTY_W), .STEP_DIV(SD), .STEP_SIZE(SS), .HOLD_W(HOLD_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .peak_duty(peak_duty),
        .hold_ticks(hold_ticks), .abort(abort), .duty_cycle(duty_cycle),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input int got, input int exp);
        ntotal++;
        if (got == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    endtask

    // Spin model: phase 0 idle, 1 rising, 2 holding, 3 falling; ticks come from cycles since acceptance.
    int m_phase, m_duty, m_busy, m_done, m_age, m_peak, m_hold, m_held;
    bit m_tick, m_accept;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = 0; m_duty = 0; m_busy = 0; m_done = 0;
            m_age = 0; m_peak = 0; m_hold = 0; m_held = 0;
        end else begin
            m_tick   = (m_phase != 0) && (m_age % SD == SD - 1);
            m_accept = 0;
            m_done   = 0;
            if (m_phase == 0) begin
                if (start) begin
                    m_peak = int'(peak_duty);
                    m_hold = int'(hold_ticks);
                    m_phase = (m_peak == 0) ? 3 : 1;
                    m_accept = 1;
                end
            end else if (m_phase == 1) begin
                if (abort) m_phase = 3;
                else if (m_duty == m_peak) begin m_phase = 2; m_held = 0; end
                else if (m_tick) m_duty = (m_duty + SS > m_peak) ? m_peak : m_duty + SS;
            end else if (m_phase == 2) begin
                if (abort || m_held == m_hold) m_phase = 3;
                else if (m_tick) m_held++;
            end else begin
                if (m_duty == 0) begin m_phase = 0; m_done = 1; end
                else if (m_tick) m_duty = (m_duty <= SS) ? 0 : m_duty - SS;
            end
            m_age  = m_accept ? 0 : m_age + 1;
            m_busy = (m_phase != 0) ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("duty_vs_model", int'(duty_cycle), m_duty);
            chk("busy_vs_model", int'(busy), m_busy);
            chk("done_vs_model", int'(done), m_done);
        end
    end

    task automatic spin(input int pk, input int hd);
        start = 1'b1; peak_duty = DUTY_W'(pk); hold_ticks = HOLD_W'(hd);
        @(posedge clk); #2;
        acc = cyc;
        start = 1'b0;
    endtask

    task automatic goto_edge(input int n);
        for (int g = 0; g < 1000 && (cyc - acc) < n; g++) begin
            @(posedge clk); #2;
        end
    endtask

    task automatic wait_done(input string nm, input int exp);
        bit seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(posedge clk); #2;
            if (done) seen = 1;
        end
        chk(nm, seen ? cyc - acc : -1, exp);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        chk("rst_duty", int'(duty_cycle), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        reset = 1'b0;
        @(posedge clk); #2;

        // Full profile: up 4..16, hold two ticks, down to 0.
        spin(16, 2);
        chk("t1_busy", int'(busy), 1);
        goto_edge(3);  chk("t1_duty_e3", int'(duty_cycle), 0);
        goto_edge(4);  chk("t1_duty_e4", int'(duty_cycle), 4);
        goto_edge(8);  chk("t1_duty_e8", int'(duty_cycle), 8);
        goto_edge(16); chk("t1_duty_e16", int'(duty_cycle), 16);
        goto_edge(28); chk("t1_duty_e28", int'(duty_cycle), 12);
        wait_done("t1_done_edge", 41);
        @(posedge clk); #2;
        chk("t1_busy_after", int'(busy), 0);
        chk("t1_done_once", int'(done), 0);

        // Saturating peak, zero hold.
        spin(10, 0);
        goto_edge(12); chk("t2_duty_e12", int'(duty_cycle), 10);
        goto_edge(16); chk("t2_duty_e16", int'(duty_cycle), 6);
        goto_edge(20); chk("t2_duty_e20", int'(duty_cycle), 2);
        wait_done("t2_done_edge", 25);
        @(posedge clk); #2;

        // Zero peak goes straight to ramp-down and finishes at once.
        spin(0, 0);
        chk("t3_busy", int'(busy), 1);
        chk("t3_duty", int'(duty_cycle), 0);
        wait_done("t3_done_edge", 1);
        chk("t3_busy_low", int'(busy), 0);

        // Start during the done cycle is accepted.
        spin(4, 0);
        chk("t7_busy", int'(busy), 1);
        goto_edge(4);  chk("t7_duty_e4", int'(duty_cycle), 4);
        wait_done("t7_done_edge", 9);
        @(posedge clk); #2;

        // Abort while rising at duty 12.
        spin(40, 0);
        goto_edge(12); chk("t4_duty_e12", int'(duty_cycle), 12);
        abort = 1'b1;
        @(posedge clk); #2;
        abort = 1'b0;
        chk("t4_duty_e13", int'(duty_cycle), 12);
        goto_edge(16); chk("t4_duty_e16", int'(duty_cycle), 8);
        wait_done("t4_done_edge", 25);
        @(posedge clk); #2;

        // Start while busy is ignored.
        spin(16, 2);
        goto_edge(8);  chk("t5_duty_e8", int'(duty_cycle), 8);
        start = 1'b1; peak_duty = 10'd100;
        @(posedge clk); #2;
        start = 1'b0;
        goto_edge(20); chk("t5_duty_e20", int'(duty_cycle), 16);
        wait_done("t5_done_edge", 41);
        @(posedge clk); #2;

        // Asynchronous reset while holding.
        spin(16, 5);
        goto_edge(18); chk("t6_duty_hold", int'(duty_cycle), 16);
        #1 reset = 1'b1;
        #1;
        chk("t6_rst_duty", int'(duty_cycle), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_done", int'(done), 0);
        @(posedge clk); #2;
        reset = 1'b0;
        @(posedge clk); #2;
        spin(8, 0);
        goto_edge(4);  chk("t6_duty_e4", int'(duty_cycle), 4);
        goto_edge(8);  chk("t6_duty_e8", int'(duty_cycle), 8);
        wait_done("t6_done_edge", 17);
        @(posedge clk); #2;

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
